// File: rtl/nrisc_multicycle_ctrl_if.sv
// Control bus between the nRisc multi-cycle controller and its datapath/memory.
// master = controller side, slave = datapath side.
interface nrisc_multicycle_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             run;
    logic [2:0]       Opcode;
    logic             Zero;
    logic             mem_ready;
    logic             PcWrite;
    logic             PcSrc;
    logic             IorD;
    logic             IrWrite;
    logic             MemRead;
    logic             MemWrite;
    logic             MemToReg;
    logic             RegWrite;
    logic             ULASrc;
    logic             Slt;
    logic             Branch;
    logic             BeqOrBne;
    logic [1:0]       ULAOp;
    logic             halted;
    logic             error;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  run, Opcode, Zero, mem_ready,
        output PcWrite, PcSrc, IorD, IrWrite, MemRead, MemWrite, MemToReg, RegWrite,
               ULASrc, Slt, Branch, BeqOrBne, ULAOp, halted, error, instr_count
    );

    modport slave (
        output run, Opcode, Zero, mem_ready,
        input  PcWrite, PcSrc, IorD, IrWrite, MemRead, MemWrite, MemToReg, RegWrite,
               ULASrc, Slt, Branch, BeqOrBne, ULAOp, halted, error, instr_count
    );
endinterface

// File: rtl/nrisc_multicycle_ctrl.sv
// Multi-cycle control FSM for the 8-bit nRisc: FETCH/DECODE/EXEC/MEM/WB with a
// memory ready handshake, timeout to ERROR, halt status and retired-instruction counter.
module nrisc_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic                    Clock,
    input  logic                    reset,
    nrisc_multicycle_ctrl_if.master bus
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERROR
    } state_t;

    state_t            state_reg;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic              fetch_pending_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              halted_reg;
    logic              error_reg;

    logic is_add, is_sub, is_slt, is_lw, is_sw, is_beq, is_bne, is_halt;
    logic fetch_req, branch_taken;

    assign is_add  = (bus.Opcode == 3'b000);
    assign is_sub  = (bus.Opcode == 3'b001);
    assign is_slt  = (bus.Opcode == 3'b010);
    assign is_lw   = (bus.Opcode == 3'b011);
    assign is_sw   = (bus.Opcode == 3'b100);
    assign is_beq  = (bus.Opcode == 3'b101);
    assign is_bne  = (bus.Opcode == 3'b110);
    assign is_halt = (bus.Opcode == 3'b111);

    // Once a fetch has been requested it stays requested even if run drops.
    assign fetch_req    = bus.run | fetch_pending_reg;
    assign branch_taken = (is_beq & bus.Zero) | (is_bne & ~bus.Zero);

    logic       mem_read, mem_write, iord, ir_write, pc_write, pc_src;
    logic       reg_write, mem_to_reg, ula_src, slt, branch, beq_or_bne;
    logic [1:0] ula_op;

    // Gating on reset makes the strobes drop the instant reset asserts.
    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        ula_src    = 1'b0;
        slt        = 1'b0;
        branch     = 1'b0;
        beq_or_bne = 1'b0;
        ula_op     = 2'b00;
        if (reset) begin
            case (state_reg)
                S_FETCH: begin
                    if (fetch_req) begin
                        mem_read = 1'b1;
                        if (bus.mem_ready) begin
                            ir_write = 1'b1;
                            pc_write = 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    if (is_sub) ula_op = 2'b01;
                    if (is_slt) begin
                        ula_op = 2'b10;
                        slt    = 1'b1;
                    end
                    if (is_lw || is_sw) ula_src = 1'b1;
                    if (is_beq || is_bne) begin
                        ula_op     = 2'b01;
                        branch     = 1'b1;
                        beq_or_bne = is_beq;
                        if (branch_taken) begin
                            pc_write = 1'b1;
                            pc_src   = 1'b1;
                        end
                    end
                end
                S_MEM: begin
                    iord      = 1'b1;
                    mem_read  = is_lw;
                    mem_write = is_sw;
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = is_lw;
                    slt        = is_slt;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            state_reg         <= S_FETCH;
            wait_cnt_reg      <= '0;
            fetch_pending_reg <= 1'b0;
            count_reg         <= '0;
            halted_reg        <= 1'b0;
            error_reg         <= 1'b0;
        end else begin
            case (state_reg)
                S_FETCH: begin
                    if (fetch_req) begin
                        if (bus.mem_ready) begin
                            state_reg         <= S_DECODE;
                            wait_cnt_reg      <= '0;
                            fetch_pending_reg <= 1'b0;
                        end else if (wait_cnt_reg == WAIT_LAST) begin
                            state_reg <= S_ERROR;
                            error_reg <= 1'b1;
                        end else begin
                            wait_cnt_reg      <= wait_cnt_reg + 1'b1;
                            fetch_pending_reg <= 1'b1;
                        end
                    end
                end
                S_DECODE: begin
                    if (is_halt) begin
                        state_reg  <= S_HALT;
                        halted_reg <= 1'b1;
                    end else begin
                        state_reg <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_add || is_sub || is_slt) begin
                        state_reg <= S_WB;
                    end else if (is_lw || is_sw) begin
                        state_reg    <= S_MEM;
                        wait_cnt_reg <= '0;
                    end else begin
                        // Branches retire here; halt cannot reach EXEC.
                        state_reg    <= S_FETCH;
                        wait_cnt_reg <= '0;
                        if (!is_halt) count_reg <= count_reg + CNT_W'(1);
                    end
                end
                S_MEM: begin
                    if (bus.mem_ready) begin
                        wait_cnt_reg <= '0;
                        if (is_lw) begin
                            state_reg <= S_WB;
                        end else begin
                            state_reg <= S_FETCH;
                            count_reg <= count_reg + CNT_W'(1);
                        end
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        state_reg <= S_ERROR;
                        error_reg <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                S_WB: begin
                    state_reg    <= S_FETCH;
                    wait_cnt_reg <= '0;
                    count_reg    <= count_reg + CNT_W'(1);
                end
                S_HALT:  state_reg <= S_HALT;
                S_ERROR: state_reg <= S_ERROR;
                default: begin
                    state_reg <= S_ERROR;
                    error_reg <= 1'b1;
                end
            endcase
        end
    end

    assign bus.MemRead     = mem_read;
    assign bus.MemWrite    = mem_write;
    assign bus.IorD        = iord;
    assign bus.IrWrite     = ir_write;
    assign bus.PcWrite     = pc_write;
    assign bus.PcSrc       = pc_src;
    assign bus.RegWrite    = reg_write;
    assign bus.MemToReg    = mem_to_reg;
    assign bus.ULASrc      = ula_src;
    assign bus.Slt         = slt;
    assign bus.Branch      = branch;
    assign bus.BeqOrBne    = beq_or_bne;
    assign bus.ULAOp       = ula_op;
    assign bus.halted      = halted_reg;
    assign bus.error       = error_reg;
    assign bus.instr_count = count_reg;
endmodule
